// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Digit-serial signed subtractor: diff = a - b - bin, modulo 2^WIDTH.
//   One DIGIT-wide slice is processed per clock, LSB slice first. A full
//   operation takes WIDTH/DIGIT RUN cycles plus one DONE cycle. The results
//   are registered, so they appear one clock after the DONE state.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high (aborts any operation)
//   start     request pulse; a, b, bin are sampled when accepted in IDLE
//   a, b      signed two's-complement operands (WIDTH bits)
//   bin       borrow-in
//   busy      high while an operation is in RUN or DONE
//   done      one-cycle pulse when diff/bout/overflow are updated
//   diff      a - b - bin, held until the next completed operation
//   bout      borrow out of the MSB (unsigned a < unsigned b + bin)
//   overflow  signed overflow of the subtraction
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

   // The result register is filled by shifting slices in from the top, so
   // at least two slices are needed.
   generate
      if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
      end
      if (WIDTH <= DIGIT) begin : g_bad_width
         $error("serial_subtractor: WIDTH must be larger than DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_r;
   logic             borrow_r;
   logic             a_msb_r;
   logic             b_msb_r;
   logic [CW-1:0]    cnt_r;
   logic [DIGIT:0]   step_s;
   logic             step_borrow_s;

   // One slice of a - b - borrow, done as a + ~b + ~borrow; the borrow out
   // of the slice is the inverted carry.
   always_comb begin
      step_s        = {1'b0, a_sh_r[DIGIT-1:0]}
                    + {1'b0, ~b_sh_r[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, ~borrow_r};
      step_borrow_s = ~step_s[DIGIT];
   end

   // Next-state logic of the IDLE -> RUN -> DONE sequencer.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == LAST_DIGIT) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register; busy is registered from the next state so it tracks
   // RUN/DONE exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         busy    <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy    <= (state_nx_s != IDLE);
      end
   end

   // Operand shift registers, borrow chain, slice counter and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         res_r    <= '0;
         borrow_r <= 1'b0;
         a_msb_r  <= 1'b0;
         b_msb_r  <= 1'b0;
         cnt_r    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_sh_r   <= a;
                  b_sh_r   <= b;
                  borrow_r <= bin;
                  // Original sign bits are kept for overflow because the
                  // shift registers lose them during RUN.
                  a_msb_r  <= a[WIDTH-1];
                  b_msb_r  <= b[WIDTH-1];
                  cnt_r    <= '0;
               end
            end
            RUN: begin
               res_r    <= {step_s[DIGIT-1:0], res_r[WIDTH-1:DIGIT]};
               borrow_r <= step_borrow_s;
               a_sh_r   <= a_sh_r >> DIGIT;
               b_sh_r   <= b_sh_r >> DIGIT;
               cnt_r    <= cnt_r + CW'(1);
            end
            DONE: begin
               cnt_r <= '0;
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   // Visible results only change when the DONE state publishes them, so
   // partial slices are never exposed.
   always_ff @(posedge clk) begin
      if (rst) begin
         done     <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= (state_r == DONE);
         if (state_r == DONE) begin
            diff     <= res_r;
            bout     <= borrow_r;
            overflow <= (a_msb_r != b_msb_r) && (res_r[WIDTH-1] != a_msb_r);
         end
      end
   end

endmodule
